// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer: phase encoding
// and instruction size.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5
  } state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned INSTR_W     = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used to count
// retired instructions.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer with a
// registered request interface and a saturating retired-instruction count.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               nreset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr,
  input  logic               need_mem,
  input  logic               do_wb,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               dmem_req,
  input  logic               dmem_ack,
  input  logic               halt,
  output logic               reg_we,
  output logic [ADDR_W-1:0]  pc,
  output logic [2:0]         phase,
  output logic [CNT_W-1:0]   retired,
  output logic               halted
);

  state_e               state_q;
  logic [ADDR_W-1:0]    pc_q;
  logic [ADDR_W-1:0]    target_q;
  logic [INSTR_W-1:0]   instr_q;
  logic                 need_mem_q;
  logic                 do_wb_q;
  logic                 taken_q;
  logic                 imem_req_q;
  logic                 dmem_req_q;
  logic                 reg_we_q;

  logic [ADDR_W-1:0]    seq_pc;
  logic                 retire;

  assign seq_pc = pc_q + ADDR_W'(INSTR_BYTES);
  assign retire = (state_q == ST_WRITEBACK);

  // NOTE: every control register sits on the asynchronous reset so a reset
  // mid-transaction drops the requests immediately, without waiting for clk.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      target_q   <= '0;
      instr_q    <= '0;
      need_mem_q <= 1'b0;
      do_wb_q    <= 1'b0;
      taken_q    <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      reg_we_q   <= 1'b0;
    end else begin
      // reg_we is a one-cycle strobe; only the WRITEBACK entry raises it.
      reg_we_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          // The request register lags state by a cycle after reset, so an
          // ack is only honoured once the request is actually visible.
          imem_req_q <= 1'b1;
          if (imem_req_q && imem_ack) begin
            instr_q    <= imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_q <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          need_mem_q <= need_mem;
          do_wb_q    <= do_wb;
          taken_q    <= branch_taken;
          target_q   <= {branch_target[ADDR_W-1:2], 2'b00};
          if (need_mem) begin
            dmem_req_q <= 1'b1;
            state_q    <= ST_MEMORY;
          end else begin
            reg_we_q <= do_wb;
            state_q  <= ST_WRITEBACK;
          end
        end
        ST_MEMORY: begin
          if (dmem_ack || !need_mem_q) begin
            dmem_req_q <= 1'b0;
            reg_we_q   <= do_wb_q;
            state_q    <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          pc_q <= taken_q ? target_q : seq_pc;
          if (halt) begin
            state_q <= ST_HALTED;
          end else begin
            imem_req_q <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
        default: begin
          imem_req_q <= 1'b0;
          dmem_req_q <= 1'b0;
          state_q    <= ST_FETCH;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_retired (
    .clk    (clk),
    .nreset (nreset),
    .clear  (1'b0),
    .inc    (retire),
    .count  (retired)
  );

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign dmem_req  = dmem_req_q;
  assign reg_we    = reg_we_q;
  assign pc        = pc_q;
  assign phase     = state_q;
  assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-instruction expectations are queued
// as stimulus is applied and compared when the instruction retires.
module tb_cpu_sequencer;

  localparam logic [2:0] P_FETCH     = 3'd0;
  localparam logic [2:0] P_DECODE    = 3'd1;
  localparam logic [2:0] P_EXECUTE   = 3'd2;
  localparam logic [2:0] P_MEMORY    = 3'd3;
  localparam logic [2:0] P_WRITEBACK = 3'd4;
  localparam logic [2:0] P_HALTED    = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: default widths, RESET_PC = 0.
  logic        nreset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        need_mem;
  logic        do_wb;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        dmem_req;
  logic        dmem_ack;
  logic        halt;
  logic        reg_we;
  logic [31:0] pc;
  logic [2:0]  phase;
  logic [15:0] retired;
  logic        halted;

  cpu_sequencer dut (
    .clk           (clk),
    .nreset        (nreset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .need_mem      (need_mem),
    .do_wb         (do_wb),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .dmem_req      (dmem_req),
    .dmem_ack      (dmem_ack),
    .halt          (halt),
    .reg_we        (reg_we),
    .pc            (pc),
    .phase         (phase),
    .retired       (retired),
    .halted        (halted)
  );

  // Narrow instance for pc wrap and counter saturation.
  logic        nreset8;
  logic        imem_req8;
  logic [7:0]  imem_addr8;
  logic [31:0] instr8;
  logic        dmem_req8;
  logic        reg_we8;
  logic [7:0]  pc8;
  logic [2:0]  phase8;
  logic [1:0]  retired8;
  logic        halted8;

  cpu_sequencer #(
    .ADDR_W   (8),
    .RESET_PC (8'hFC),
    .CNT_W    (2)
  ) dut8 (
    .clk           (clk),
    .nreset        (nreset8),
    .imem_req      (imem_req8),
    .imem_addr     (imem_addr8),
    .imem_ack      (1'b1),
    .imem_rdata    (32'h0000_0013),
    .instr         (instr8),
    .need_mem      (1'b0),
    .do_wb         (1'b1),
    .branch_taken  (1'b0),
    .branch_target (8'h00),
    .dmem_req      (dmem_req8),
    .dmem_ack      (1'b0),
    .halt          (1'b0),
    .reg_we        (reg_we8),
    .pc            (pc8),
    .phase         (phase8),
    .retired       (retired8),
    .halted        (halted8)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [15:0] retired;
    int          req_cycles;
    int          dreq_cycles;
    int          cycles;
    int          we;
    logic [2:0]  phase;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  sb8[$];
  logic [31:0] m_pc;
  logic [15:0] m_ret;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in FETCH and imem_req high; returns at
  // the negedge just after the instruction leaves WRITEBACK.
  task automatic run_instr(input string tag, input int ack_delay, input logic [31:0] rdata,
                           input logic nm, input int dmem_delay, input logic wb,
                           input logic br, input logic [31:0] tgt, input logic hlt);
    exp_t        e;
    int          reqc;
    int          dreqc;
    int          cyc;
    int          we;
    int          fw;
    int          mw;
    logic        addr_ok;
    logic [31:0] addr0;
    bit          done;

    e.instr       = rdata;
    e.pc          = br ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
    e.retired     = (m_ret == 16'hFFFF) ? m_ret : m_ret + 16'd1;
    e.req_cycles  = ack_delay + 1;
    e.dreq_cycles = nm ? dmem_delay + 1 : 0;
    e.cycles      = ack_delay + 1 + 3 + (nm ? dmem_delay + 1 : 0);
    e.we          = wb ? 1 : 0;
    e.phase       = hlt ? P_HALTED : P_FETCH;
    sb.push_back(e);

    check({tag, ".fetch_addr"}, imem_addr, m_pc);
    m_pc  = e.pc;
    m_ret = e.retired;

    need_mem      = nm;
    do_wb         = wb;
    branch_taken  = br;
    branch_target = tgt;
    halt          = hlt;

    reqc = 0; dreqc = 0; cyc = 0; we = 0; fw = 0; mw = 0;
    addr_ok = 1'b1;
    addr0   = imem_addr;
    done    = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      if (phase === P_FETCH) begin
        if (imem_req) reqc++;
        if (imem_addr !== addr0) addr_ok = 1'b0;
        imem_rdata = rdata;
        imem_ack   = (fw == ack_delay);
        fw++;
      end else begin
        // Stray acks and changing rdata outside FETCH must be ignored.
        imem_rdata = ~rdata;
        imem_ack   = 1'b1;
      end
      if (phase === P_MEMORY) begin
        if (dmem_req) dreqc++;
        dmem_ack = (mw == dmem_delay);
        mw++;
      end else begin
        dmem_ack = 1'b1;
      end
      if (reg_we) we++;
      if (phase === P_WRITEBACK) done = 1'b1;
      @(negedge clk);
      cyc++;
    end

    check({tag, ".completed"}, done, 1'b1);
    e = sb.pop_front();
    check({tag, ".instr"},       instr,    e.instr);
    check({tag, ".req_cycles"},  reqc,     e.req_cycles);
    check({tag, ".addr_stable"}, addr_ok,  1'b1);
    check({tag, ".dreq_cycles"}, dreqc,    e.dreq_cycles);
    check({tag, ".cycles"},      cyc,      e.cycles);
    check({tag, ".reg_we"},      we,       e.we);
    check({tag, ".next_pc"},     pc,       e.pc);
    check({tag, ".retired"},     retired,  e.retired);
    check({tag, ".phase"},       phase,    e.phase);
    check({tag, ".halted"},      halted,   (e.phase == P_HALTED));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   fetches;
    bit   found;
    nreset        = 1'b0;
    nreset8       = 1'b0;
    imem_ack      = 1'b1;
    imem_rdata    = 32'h0;
    need_mem      = 1'b0;
    do_wb         = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    dmem_ack      = 1'b0;
    halt          = 1'b0;
    #12;

    check("rst.phase",    phase,    P_FETCH);
    check("rst.pc",       pc,       32'h0);
    check("rst.imem_req", imem_req, 1'b0);
    check("rst.dmem_req", dmem_req, 1'b0);
    check("rst.reg_we",   reg_we,   1'b0);
    check("rst.halted",   halted,   1'b0);
    check("rst.retired",  retired,  16'h0);
    check("rst.instr",    instr,    32'h0);

    @(negedge clk);
    nreset = 1'b1;
    #1 check("rel.req_low", imem_req, 1'b0);
    @(negedge clk);
    check("rel.req_first_edge", imem_req, 1'b1);
    m_pc  = 32'h0;
    m_ret = 16'h0;

    // Back-to-back zero-wait instructions: pc 0,4,8 at 4-cycle spacing.
    run_instr("seq0", 0, 32'h0010_0093, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    run_instr("seq1", 0, 32'h0020_0113, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    run_instr("seq2", 0, 32'h0030_0193, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    // Slow fetch: ack on the fourth request cycle.
    run_instr("slowfetch", 3, 32'hE3A0_1005, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    // Branch at 0x10 with an unaligned target; no register write.
    run_instr("branch", 0, 32'hEA00_0040, 1'b0, 0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    // Memory access with two wait cycles, then zero-wait.
    run_instr("mem_wait", 0, 32'hE591_2000, 1'b1, 2, 1'b1, 1'b0, 32'h0, 1'b0);
    run_instr("mem_fast", 1, 32'hE581_2004, 1'b1, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    // Halt in WRITEBACK; pc and retired still advance.
    run_instr("halt", 0, 32'hEF00_0000, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b1);

    halt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("halted.imem_req", imem_req, 1'b0);
      check("halted.flag",     {halted, dmem_req, reg_we, phase}, {1'b1, 1'b0, 1'b0, P_HALTED});
    end
    check("halted.retired_hold", retired, m_ret);

    // Reset mid-MEMORY abandons the data request at once.
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    m_pc  = 32'h0;
    m_ret = 16'h0;
    run_instr("pre_abort", 0, 32'h1111_0000, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    imem_ack = 1'b1;
    need_mem = 1'b1;
    dmem_ack = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      imem_ack = 1'b1;
      dmem_ack = 1'b0;
      if (phase === P_MEMORY) found = 1'b1;
    end
    check("abort.reached_memory", found, 1'b1);
    check("abort.dmem_req_before", dmem_req, 1'b1);
    #2 nreset = 1'b0;
    #1;
    check("abort.dmem_req", dmem_req, 1'b0);
    check("abort.pc",       pc,       32'h0);
    check("abort.state",    {phase, imem_req, reg_we, halted}, {P_FETCH, 1'b0, 1'b0, 1'b0});
    check("abort.retired",  retired,  16'h0);
    check("abort.instr",    instr,    32'h0);
    @(negedge clk);
    check("abort.no_we", reg_we, 1'b0);
    nreset   = 1'b1;
    need_mem = 1'b0;

    // Narrow instance: pc wraps 0xFC -> 0x00, 2-bit retired saturates at 3.
    sb8 = {8'hFC, 8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
    @(negedge clk);
    nreset8 = 1'b1;
    fetches = 0;
    for (int k = 0; k < 60 && fetches < 6; k++) begin
      @(negedge clk);
      if (phase8 === P_FETCH && imem_req8) begin
        check("narrow.fetch_addr", imem_addr8, sb8.pop_front());
        fetches++;
        if (fetches == 6) check("narrow.retired_sat", retired8, 2'd3);
      end
    end
    check("narrow.fetch_count", fetches, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
